// File: rtl/meb_lsu_pkg.sv
// meb_lsu shared definitions: op codes, FSM states, byte-lane selects, op decode.
package meb_lsu_pkg;

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam logic [7:0] OP_LL  = 8'hF0;
  localparam logic [7:0] OP_SC  = 8'hF8;

  typedef enum logic [1:0] {
    LsuIdle  = 2'd0,
    LsuWait  = 2'd1,
    LsuDone  = 2'd2,
    LsuDrain = 2'd3
  } lsu_state_e;

  // Big-endian lane selects: byte address 0 lives in bits 31:24.
  localparam logic [3:0] ByteSel0 = 4'b1000;
  localparam logic [3:0] ByteSel1 = 4'b0100;
  localparam logic [3:0] ByteSel2 = 4'b0010;
  localparam logic [3:0] ByteSel3 = 4'b0001;
  localparam logic [3:0] HalfSel0 = 4'b1100;
  localparam logic [3:0] HalfSel1 = 4'b0011;
  localparam logic [3:0] WordSel  = 4'b1111;

  typedef enum logic [1:0] {
    SzByte = 2'd0,
    SzHalf = 2'd1,
    SzWord = 2'd2
  } lsu_size_e;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    logic      sgn;
    lsu_size_e size;
    logic      is_ll;
    logic      is_sc;
  } op_dec_t;

  function automatic op_dec_t lsu_decode(input logic [7:0] op);
    op_dec_t d;
    d = '0;
    case (op)
      OP_LB:  begin d.is_load = 1'b1; d.sgn = 1'b1; d.size = SzByte; end
      OP_LBU: begin d.is_load = 1'b1; d.size = SzByte; end
      OP_LH:  begin d.is_load = 1'b1; d.sgn = 1'b1; d.size = SzHalf; end
      OP_LHU: begin d.is_load = 1'b1; d.size = SzHalf; end
      OP_LW:  begin d.is_load = 1'b1; d.size = SzWord; end
      OP_LL:  begin d.is_load = 1'b1; d.size = SzWord; d.is_ll = 1'b1; end
      OP_SB:  begin d.is_store = 1'b1; d.size = SzByte; end
      OP_SH:  begin d.is_store = 1'b1; d.size = SzHalf; end
      OP_SW:  begin d.is_store = 1'b1; d.size = SzWord; end
      OP_SC:  begin d.is_store = 1'b1; d.size = SzWord; d.is_sc = 1'b1; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/meb_lsu_lane.sv
// Byte-lane steering: bus_sel, store-data replication, load extraction/extension.
module meb_lsu_lane
  import meb_lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic        sgn,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misalign
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select / replicate / extract for the given size and low address bits.
  always_comb begin
    sel      = WordSel;
    wdata    = sdata;
    ldata    = rdata;
    misalign = |addr_lo;
    byte_v   = rdata[31:24];
    half_v   = rdata[31:16];
    case (size)
      SzByte: begin
        misalign = 1'b0;
        wdata    = {4{sdata[7:0]}};
        case (addr_lo)
          2'b00:   begin sel = ByteSel0; byte_v = rdata[31:24]; end
          2'b01:   begin sel = ByteSel1; byte_v = rdata[23:16]; end
          2'b10:   begin sel = ByteSel2; byte_v = rdata[15:8];  end
          default: begin sel = ByteSel3; byte_v = rdata[7:0];   end
        endcase
        ldata = {{24{sgn & byte_v[7]}}, byte_v};
      end
      SzHalf: begin
        misalign = addr_lo[0];
        wdata    = {2{sdata[15:0]}};
        if (addr_lo[1]) begin
          sel    = HalfSel1;
          half_v = rdata[15:0];
        end else begin
          sel    = HalfSel0;
          half_v = rdata[31:16];
        end
        ldata = {{16{sgn & half_v[15]}}, half_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/meb_lsu.sv
// MIPS32 memory-access stage: req/ack data bus, alignment, LL/SC, write-back mux.
module meb_lsu
  import meb_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  input  logic [4:0]  mem_w_add,
  input  logic        mem_w_reg,
  input  logic [31:0] mem_w_data,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  output logic        stallreq,
  output logic [4:0]  meb_w_add,
  output logic        meb_w_reg,
  output logic [31:0] meb_w_data,
  output logic        excp_adel,
  output logic        excp_ades,
  output logic        excp_dbe
);

  lsu_state_e state_q, state_d;
  op_dec_t    dec_in;
  logic       is_mem;

  // Transaction context latched at issue; EX/MEM is stalled, but keep our own copy.
  logic       ld_q, sc_q, ll_q, sgn_q;
  lsu_size_e  size_q;
  logic [1:0] alo_q;
  logic [4:0] wadd_q;
  logic       wreg_q;
  logic [31:0] rdata_q;
  logic       err_q;
  logic       llbit_q;
  logic [7:0] tmo_q;

  logic       start, tmo_hit, bus_end;
  lsu_size_e  lane_size;
  logic       lane_sgn;
  logic [1:0] lane_alo;
  logic [3:0] lane_sel;
  logic [31:0] lane_wdata, lane_ldata;
  logic       lane_mis;

  assign dec_in = lsu_decode(mem_aluop);
  assign is_mem = dec_in.is_load | dec_in.is_store;

  // One lane unit: in IDLE it steers the incoming op, otherwise it extracts for DONE.
  assign lane_size = (state_q == LsuIdle) ? dec_in.size    : size_q;
  assign lane_sgn  = (state_q == LsuIdle) ? dec_in.sgn     : sgn_q;
  assign lane_alo  = (state_q == LsuIdle) ? mem_addr[1:0]  : alo_q;

  meb_lsu_lane u_lane (
    .size     (lane_size),
    .sgn      (lane_sgn),
    .addr_lo  (lane_alo),
    .sdata    (mem_sdata),
    .rdata    (rdata_q),
    .sel      (lane_sel),
    .wdata    (lane_wdata),
    .ldata    (lane_ldata),
    .misalign (lane_mis)
  );

  // Forced error fires on the TIMEOUT-th WAIT cycle; counter saturates at 8'hFF.
  assign tmo_hit = (state_q == LsuWait || state_q == LsuDrain) &&
                   ((int'(tmo_q) + 1) >= TIMEOUT);
  assign bus_end = bus_ack | bus_err | tmo_hit;

  // Next-state and combinational write-back / stall / exception outputs.
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    stallreq   = 1'b0;
    meb_w_add  = 5'd0;
    meb_w_reg  = 1'b0;
    meb_w_data = 32'd0;
    excp_adel  = 1'b0;
    excp_ades  = 1'b0;
    excp_dbe   = 1'b0;
    if (!rst) begin
      state_d = LsuIdle;
    end else begin
      case (state_q)
        LsuIdle: begin
          if (flush) begin
            state_d = LsuIdle;
          end else if (!is_mem) begin
            meb_w_add  = mem_w_add;
            meb_w_reg  = mem_w_reg;
            meb_w_data = mem_w_data;
          end else if (lane_mis) begin
            excp_adel = ~dec_in.is_store;
            excp_ades = dec_in.is_store;
          end else if (dec_in.is_sc && !llbit_q) begin
            // Failed SC: no bus traffic, rt <= 0 immediately.
            meb_w_add  = mem_w_add;
            meb_w_reg  = 1'b1;
            meb_w_data = 32'd0;
          end else begin
            start    = 1'b1;
            stallreq = 1'b1;
            state_d  = LsuWait;
          end
        end
        LsuWait: begin
          stallreq = 1'b1;
          // A flush that coincides with the bus response has nothing left to drain.
          if (flush)        state_d = bus_end ? LsuIdle : LsuDrain;
          else if (bus_end) state_d = LsuDone;
        end
        LsuDone: begin
          state_d = LsuIdle;
          if (!flush) begin
            meb_w_add = wadd_q;
            if (err_q) begin
              excp_dbe = 1'b1;
            end else if (sc_q) begin
              meb_w_reg  = 1'b1;
              meb_w_data = 32'd1;
            end else if (ld_q) begin
              meb_w_reg  = wreg_q;
              meb_w_data = lane_ldata;
            end
          end
        end
        default: begin
          stallreq = 1'b1;
          if (bus_end) state_d = LsuIdle;
        end
      endcase
    end
  end

  // State, bus request registers, captured data, timeout counter and llbit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= LsuIdle;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_sel   <= 4'd0;
      bus_wdata <= 32'd0;
      ld_q      <= 1'b0;
      sc_q      <= 1'b0;
      ll_q      <= 1'b0;
      sgn_q     <= 1'b0;
      size_q    <= SzByte;
      alo_q     <= 2'd0;
      wadd_q    <= 5'd0;
      wreg_q    <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      llbit_q   <= 1'b0;
      tmo_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      if (start) begin
        bus_req   <= 1'b1;
        bus_we    <= dec_in.is_store;
        bus_addr  <= {mem_addr[31:2], 2'b00};
        bus_sel   <= lane_sel;
        bus_wdata <= lane_wdata;
        ld_q      <= dec_in.is_load;
        sc_q      <= dec_in.is_sc;
        ll_q      <= dec_in.is_ll;
        sgn_q     <= dec_in.sgn;
        size_q    <= dec_in.size;
        alo_q     <= mem_addr[1:0];
        wadd_q    <= mem_w_add;
        wreg_q    <= mem_w_reg;
        err_q     <= 1'b0;
        tmo_q     <= 8'd0;
      end else if (state_q == LsuWait || state_q == LsuDrain) begin
        if (tmo_q != 8'hFF) tmo_q <= tmo_q + 8'd1;
        if (bus_end) bus_req <= 1'b0;
        if (state_q == LsuWait) begin
          // err beats ack; ack beats a timeout landing on the same cycle
          if (bus_err || (tmo_hit && !bus_ack)) err_q <= 1'b1;
          if (bus_ack && !bus_err)              rdata_q <= bus_rdata;
        end
      end
      if (flush)                                       llbit_q <= 1'b0;
      else if (start && dec_in.is_sc)                  llbit_q <= 1'b0;
      else if (state_q == LsuDone && ll_q && !err_q)   llbit_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_meb_lsu.sv
// Scoreboard bench for meb_lsu: driver pushes expectations, monitor checks completions.
module tb_meb_lsu;
  import meb_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  mem_aluop = 8'h00;
  logic [31:0] mem_addr = '0, mem_sdata = '0, mem_w_data = '0;
  logic [4:0]  mem_w_add = '0;
  logic        mem_w_reg = 1'b0, flush = 1'b0;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0, bus_err = 1'b0;
  logic        stallreq;
  logic [4:0]  meb_w_add;
  logic        meb_w_reg;
  logic [31:0] meb_w_data;
  logic        excp_adel, excp_ades, excp_dbe;

  always #5 clk = ~clk;

  meb_lsu #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .mem_aluop(mem_aluop), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
    .mem_w_add(mem_w_add), .mem_w_reg(mem_w_reg), .mem_w_data(mem_w_data),
    .flush(flush),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .stallreq(stallreq),
    .meb_w_add(meb_w_add), .meb_w_reg(meb_w_reg), .meb_w_data(meb_w_data),
    .excp_adel(excp_adel), .excp_ades(excp_ades), .excp_dbe(excp_dbe)
  );

  typedef struct {
    string       name;
    logic        wreg;
    logic [31:0] wdata;
    logic [4:0]  wadd;
    logic [2:0]  excp;   // {adel, ades, dbe}
    int          stalls;
    logic        bus;
    logic        we;
    logic [31:0] baddr;
    logic [3:0]  sel;
    logic [31:0] bwdata;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;
  logic op_active = 1'b0;
  logic flush_phase = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic exp_t mk(input string nm, input logic wreg, input logic [31:0] wdata,
                              input logic [4:0] wadd, input logic [2:0] excp, input int stalls,
                              input logic bus, input logic we, input logic [31:0] baddr,
                              input logic [3:0] sel, input logic [31:0] bwdata);
    exp_t e;
    e.name = nm; e.wreg = wreg; e.wdata = wdata; e.wadd = wadd; e.excp = excp;
    e.stalls = stalls; e.bus = bus; e.we = we; e.baddr = baddr; e.sel = sel; e.bwdata = bwdata;
    return e;
  endfunction

  // Monitor: counts stall cycles per op, records the bus request, checks on completion.
  initial begin : monitor
    int          stl;
    logic        seen;
    logic        s_we;
    logic [31:0] s_addr, s_wd;
    logic [3:0]  s_sel;
    exp_t        e;
    stl = 0; seen = 1'b0; s_we = 1'b0; s_addr = '0; s_wd = '0; s_sel = '0;
    forever begin
      @(negedge clk);
      if (!op_active) begin
        stl = 0;
        seen = 1'b0;
      end else begin
        if (bus_req && !seen) begin
          seen = 1'b1; s_we = bus_we; s_addr = bus_addr; s_sel = bus_sel; s_wd = bus_wdata;
        end
        if (flush_phase) chk("flush_wreg", 32'(meb_w_reg), 32'd0);
        if (stallreq) stl++;
        else if (sb_q.size() == 0) begin
          chk("sb_empty", 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, "_stalls"}, stl, e.stalls);
          chk({e.name, "_wreg"}, 32'(meb_w_reg), 32'(e.wreg));
          if (e.wreg) begin
            chk({e.name, "_wdata"}, meb_w_data, e.wdata);
            chk({e.name, "_wadd"}, 32'(meb_w_add), 32'(e.wadd));
          end
          chk({e.name, "_excp"}, 32'({excp_adel, excp_ades, excp_dbe}), 32'(e.excp));
          chk({e.name, "_bus"}, 32'(seen), 32'(e.bus));
          if (e.bus && seen) begin
            chk({e.name, "_baddr"}, s_addr, e.baddr);
            chk({e.name, "_bsel"}, 32'(s_sel), 32'(e.sel));
            chk({e.name, "_bwe"}, 32'(s_we), 32'(e.we));
            if (e.we) chk({e.name, "_bwdata"}, s_wd, e.bwdata);
          end
          stl = 0;
          seen = 1'b0;
        end
      end
    end
  end

  // mode: 0 ack, 1 err, 2 ack+err, 3 never respond, 4 flush on first WAIT then ack
  task automatic run(input exp_t e, input logic [7:0] op, input logic [31:0] addr,
                     input logic [31:0] sdata, input logic [31:0] rdata, input int k,
                     input int mode);
    int r;
    int cyc;
    sb_q.push_back(e);
    @(posedge clk); #1;
    mem_aluop = op; mem_addr = addr; mem_sdata = sdata; mem_w_add = e.wadd;
    mem_w_reg = 1'b1;
    // memory ops must not leak mem_w_data through
    mem_w_data = (op[7:5] == 3'b111) ? ~e.wdata : e.wdata;
    bus_rdata = 32'hBAD0_BAD0;
    op_active = 1'b1; r = 0; cyc = 0;
    forever begin
      #1;
      if (!stallreq) break;
      cyc++;
      if (cyc > 400) begin
        chk({e.name, "_cycle_budget"}, 32'(cyc), 32'd400);
        break;
      end
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_err = 1'b0; flush = 1'b0; bus_rdata = 32'hBAD0_BAD0;
      if (bus_req) r++;
      if (mode == 4 && r == 1) begin
        flush = 1'b1; flush_phase = 1'b1; mem_aluop = 8'h00; mem_w_reg = 1'b0;
      end
      if (r == k + 1) begin
        case (mode)
          0, 4: begin bus_ack = 1'b1; bus_rdata = rdata; end
          1:    bus_err = 1'b1;
          2:    begin bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = rdata; end
          default: ;
        endcase
      end
    end
    @(posedge clk); #1;
    op_active = 1'b0; flush_phase = 1'b0; flush = 1'b0;
    bus_ack = 1'b0; bus_err = 1'b0; mem_aluop = 8'h00; mem_w_reg = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset with a live memory op on the inputs: everything must stay quiet.
    mem_aluop = OP_LW; mem_addr = 32'h100; mem_w_reg = 1'b1; mem_w_add = 5'd9;
    mem_w_data = 32'h1111_2222;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_sel", 32'(bus_sel), 32'd0);
    chk("rst_stallreq", 32'(stallreq), 32'd0);
    chk("rst_meb", {meb_w_data[26:0], meb_w_add}, 32'd0);
    chk("rst_wreg_excp", 32'({meb_w_reg, excp_adel, excp_ades, excp_dbe}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; mem_aluop = 8'h00; mem_w_reg = 1'b0;

    //  name         wreg wdata          wadd excp stl bus we  baddr       sel      bwdata
    run(mk("alu",    1, 32'h0000_0042, 5'd2, 3'b000, 0, 0, 0, 32'h0,     4'h0,    32'h0), 8'h21, 32'h0, 32'h0, 32'h0, 0, 0);
    run(mk("lw",     1, 32'h1234_5678, 5'd3, 3'b000, 5, 1, 0, 32'h100,   4'b1111, 32'h0), OP_LW,  32'h100, 32'h0, 32'h1234_5678, 3, 0);
    run(mk("lb",     1, 32'hFFFF_FFFF, 5'd4, 3'b000, 3, 1, 0, 32'h100,   4'b0100, 32'h0), OP_LB,  32'h101, 32'h0, 32'h80FF_0000, 1, 0);
    run(mk("lbu",    1, 32'h0000_00FF, 5'd5, 3'b000, 3, 1, 0, 32'h100,   4'b0100, 32'h0), OP_LBU, 32'h101, 32'h0, 32'h80FF_0000, 1, 0);
    run(mk("lh",     1, 32'hFFFF_ABCD, 5'd6, 3'b000, 4, 1, 0, 32'h100,   4'b0011, 32'h0), OP_LH,  32'h102, 32'h0, 32'h1234_ABCD, 2, 0);
    run(mk("lhu",    1, 32'h0000_1234, 5'd7, 3'b000, 3, 1, 0, 32'h100,   4'b1100, 32'h0), OP_LHU, 32'h100, 32'h0, 32'h1234_ABCD, 1, 0);
    run(mk("sb",     0, 32'h0,         5'd8, 3'b000, 3, 1, 1, 32'h200,   4'b0001, 32'hA7A7_A7A7), OP_SB, 32'h203, 32'h0000_00A7, 32'h0, 1, 0);
    run(mk("sh_mis", 0, 32'h0,         5'd9, 3'b010, 0, 0, 0, 32'h0,     4'h0,    32'h0), OP_SH,  32'h203, 32'h1, 32'h0, 1, 0);
    run(mk("lw_mis", 0, 32'h0,         5'd9, 3'b100, 0, 0, 0, 32'h0,     4'h0,    32'h0), OP_LW,  32'h202, 32'h0, 32'h0, 1, 0);
    run(mk("sw",     0, 32'h0,         5'd10, 3'b000, 4, 1, 1, 32'h300,  4'b1111, 32'hCAFE_F00D), OP_SW, 32'h300, 32'hCAFE_F00D, 32'h0, 2, 0);
    run(mk("sh",     0, 32'h0,         5'd11, 3'b000, 3, 1, 1, 32'h300,  4'b0011, 32'hBEEF_BEEF), OP_SH, 32'h302, 32'h1111_BEEF, 32'h0, 1, 0);
    run(mk("ll",     1, 32'h0000_0007, 5'd12, 3'b000, 3, 1, 0, 32'h40,   4'b1111, 32'h0), OP_LL,  32'h40, 32'h0, 32'h0000_0007, 1, 0);
    run(mk("sc_ok",  1, 32'h0000_0001, 5'd13, 3'b000, 3, 1, 1, 32'h40,   4'b1111, 32'h0000_0099), OP_SC, 32'h40, 32'h99, 32'h0, 1, 0);
    run(mk("sc_bad", 1, 32'h0000_0000, 5'd14, 3'b000, 0, 0, 0, 32'h0,    4'h0,    32'h0), OP_SC,  32'h40, 32'h99, 32'h0, 1, 0);
    run(mk("ll2",    1, 32'h0000_0055, 5'd15, 3'b000, 3, 1, 0, 32'h44,   4'b1111, 32'h0), OP_LL,  32'h44, 32'h0, 32'h0000_0055, 1, 0);
    run(mk("flush",  0, 32'h0,         5'd16, 3'b000, 4, 1, 0, 32'h100,  4'b1111, 32'h0), OP_LW,  32'h100, 32'h0, 32'hFEED_0001, 2, 4);
    run(mk("sc_fl",  1, 32'h0000_0000, 5'd17, 3'b000, 0, 0, 0, 32'h0,    4'h0,    32'h0), OP_SC,  32'h44, 32'h5, 32'h0, 1, 0);
    run(mk("tmo",    0, 32'h0,         5'd18, 3'b001, 256, 1, 0, 32'h500, 4'b1111, 32'h0), OP_LW, 32'h500, 32'h0, 32'h0, 1, 3);
    run(mk("ackerr", 0, 32'h0,         5'd19, 3'b001, 3, 1, 0, 32'h504,  4'b1111, 32'h0), OP_LW,  32'h504, 32'h0, 32'h1357_9BDF, 1, 2);
    run(mk("err",    0, 32'h0,         5'd20, 3'b001, 4, 1, 0, 32'h508,  4'b1111, 32'h0), OP_LW,  32'h508, 32'h0, 32'h0, 2, 1);
    run(mk("lw_rec", 1, 32'h0BAD_CAFE, 5'd21, 3'b000, 3, 1, 0, 32'h60C,  4'b1111, 32'h0), OP_LW,  32'h60C, 32'h0, 32'h0BAD_CAFE, 1, 0);

    // Reset in the middle of a transaction drops the request at the next edge.
    @(posedge clk); #1;
    mem_aluop = OP_LW; mem_addr = 32'h600; mem_w_reg = 1'b1;
    @(posedge clk); #1;
    chk("mid_req_up", 32'(bus_req), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_req", 32'(bus_req), 32'd0);
    chk("mid_rst_stall", 32'(stallreq), 32'd0);
    rst = 1'b1; mem_aluop = 8'h00; mem_w_reg = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'({bus_req, stallreq}), 32'd0);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/meb_lsu.md
# meb_lsu

Memory-access stage of the MIPS32 pipeline: it takes load/store operations from the EX/MEM register and runs them on the data bus with a req/ack handshake. It aligns and extends read data and implements LL/SC. It produces the write-back triple consumed by the MEM/WB register (`meb_wb`), and stalls the pipeline through `stallreq` while a bus transaction is outstanding.

## Interface
- `TIMEOUT`, default 255: WAIT cycles without ack/err before a bus error is forced.
- `clk  in  1`: clock.
- `rst  in  1`: reset, synchronous, active-low (`RstEnable` = 0).
- `mem_aluop  in  8`: operation code. Codes: LB, LBU, LH, LHU, LW, LL, SB, SH, SW, SC; any other code passes through.
- `mem_addr  in  32`: effective address.
- `mem_sdata  in  32`: store data (rt).
- `mem_w_add  in  5`, `mem_w_reg  in  1`, `mem_w_data  in  32`: write-back triple from EX.
- `flush  in  1`: exception flush.
- `bus_req  out  1`, `bus_we  out  1`, `bus_addr  out  32`, `bus_sel  out  4`, `bus_wdata  out  32`: bus request.
- `bus_rdata  in  32`, `bus_ack  in  1`, `bus_err  in  1`: bus response.
- `stallreq  out  1`: stall request to the controller, which drives stall[4].
- `meb_w_add  out  5`, `meb_w_reg  out  1`, `meb_w_data  out  32`: to `meb_wb`.
- `excp_adel  out  1`, `excp_ades  out  1`, `excp_dbe  out  1`: load-address, store-address and bus-error exceptions.

## Operation
- FSM states: IDLE, WAIT, DONE, DRAIN.
- **IDLE, non-memory op**
  - `meb_*` = `mem_*` combinationally.
  - `stallreq` = 0.
- **IDLE, memory op, aligned**
  - Register `bus_addr` = {addr[31:2],2'b00}, `bus_we`, `bus_sel` and the lane-replicated `bus_wdata`.
  - Assert `bus_req` from the next cycle and go to WAIT.
  - `stallreq` = 1 combinationally in this cycle.
- **Alignment**
  - Half ops require addr[0] = 0; word ops and LL/SC require addr[1:0] = 00.
  - A misaligned op makes no bus access: `excp_adel` or `excp_ades` = 1 for that cycle and `meb_w_reg` = 0.
- **Endianness**: big-endian.
  - addr[1:0] = 00 selects bits 31:24 (`bus_sel` 4'b1000).
  - Half at 00 selects 4'b1100; half at 10 selects 4'b0011.
  - Word selects 4'b1111.
- **WAIT**
  - Bus outputs are held stable and `stallreq` = 1.
  - `bus_ack`: capture `bus_rdata` and go to DONE.
  - `bus_err`, or the timeout counter reaching `TIMEOUT`: set the error flag and go to DONE.
- **DONE** (one cycle)
  - `bus_req` = 0 and `stallreq` = 0.
  - Loads: `meb_w_data` = the captured lane, sign- or zero-extended. `meb_w_reg` = `mem_w_reg`.
  - Stores: `meb_w_reg` = 0.
  - SC: `meb_w_reg` = 1 and `meb_w_data` = 1.
  - Error flag set: `excp_dbe` = 1 and `meb_w_reg` = 0.
  - Next state is IDLE.
- **LL/SC** (`llbit` register)
  - LL completing sets `llbit`.
  - SC with `llbit` = 0 makes no bus access and writes rt = 0 in the same cycle.
  - SC with `llbit` = 1 stores and clears `llbit`.
  - `flush` clears `llbit`.
- **flush**
  - In IDLE or DONE: `meb_w_reg` = 0 and exceptions = 0; the state returns to or stays in IDLE.
  - In WAIT: go to DRAIN.
- **DRAIN**
  - Keep the bus request until ack or err; discard the data.
  - `meb_w_reg` = 0 and `stallreq` = 1.
  - Next state is IDLE.

## Timing
- **Reset values**:
  - State IDLE, all `bus_*` outputs 0, `stallreq` 0 and `llbit` 0.
  - `meb_w_add` 0, `meb_w_reg` 0, `meb_w_data` 0 and all `excp_*` 0.
  - Reset mid-transaction abandons the request immediately.
- **Load latency**: ack k cycles after `bus_req` rises (k ≥ 1) gives data on `meb_*` after k+2 cycles of `stallreq`. `meb_wb` captures it on the DONE edge.
- **Data capture**: `bus_rdata` is sampled only on the cycle where `bus_ack` is high.
- **Simultaneous ack and err**: err wins.
- **Timeout counter**: 8-bit, saturating, cleared on entry to WAIT.
- **Bus stability**: `bus_addr`, `bus_sel` and `bus_wdata` are registered and do not change while `bus_req` = 1.

## Structure
- Add to `defines.v`:
  - the LB…SC op codes;
  - the state encodings `LsuIdle`, `LsuWait`, `LsuDone`, `LsuDrain`;
  - `ByteSel` constants.
- Sub-module `meb_lsu_lane`: combinational; computes `bus_sel`, `bus_wdata` replication and read-data extraction/extension from op and addr[1:0].

## Test plan
- LW at 0x100, ack after 3 cycles, rdata 0x12345678 → `stallreq` high for 5 cycles; `meb_w_data` = 0x12345678 and `meb_w_reg` = 1 in DONE.
- LB at 0x101 with rdata 0x80FF0000 → `bus_sel` 4'b0100, `meb_w_data` 0xFFFFFFFF. LBU at the same address → 0x000000FF.
- SH at 0x203 → no `bus_req`, `excp_ades` = 1, `meb_w_reg` = 0. LW at 0x202 → `excp_adel` = 1.
- LL at 0x40 then SC → SC stores, rt = 1. A second SC → no bus access, rt = 0, zero stall cycles.
- `flush` during WAIT, ack 2 cycles later → DRAIN, `meb_w_reg` = 0 throughout, back to IDLE, `llbit` = 0.
- Bus never acks → `excp_dbe` = 1 after 255 WAIT cycles. `bus_err` and `bus_ack` together → `excp_dbe` = 1.
